axis_frame_builder: RTL and testbench
=====================================

// Module: axis_frame_builder
// PURPOSE
//  Transmit-side framer for the DMA path: collects one trigger window of raw 128-bit sample lines
//  (8 x 16-bit samples per line) and emits it as a framed AXI4-Stream packet (header line,
//  data lines, footer line with TLAST). It sits upstream of axi_dma_connector and feeds it.
//  The header carries the frame length, so the block buffers the whole window before sending.
// PARAMETERS
//  TDATA_WIDTH         128    stream width; only 128 is supported
//  CHANNEL_ID_WIDTH    12     header channel field width
//  FRAME_LENGTH_WIDTH  12     header length field width
//  MAX_TRIGGER_LENGTH  16     max data lines per frame; power of 2, >=2
//  HEADER_ID           8'hAA  header marker
//  FOOTER_ID           8'h55  footer marker
// PORTS
//  ACLK           in   1    clock
//  ARESETN        in   1    async active-low reset
//  CHANNEL_ID     in   12   channel tag; sampled on the first accepted data line of a window
//  S_AXIS_TDATA   in   128  raw sample line
//  S_AXIS_TVALID  in   1    sample line valid
//  S_AXIS_TLAST   in   1    last line of the trigger window
//  S_AXIS_TREADY  out  1    ready; high only in IDLE/COLLECT
//  M_AXIS_TDATA   out  128  framed output line
//  M_AXIS_TKEEP   out  16   byte keep
//  M_AXIS_TVALID  out  1    output valid
//  M_AXIS_TLAST   out  1    high on footer line only
//  M_AXIS_TREADY  in   1    downstream ready
//  OVERFLOW       out  1    one-cycle pulse when a window exceeded MAX_TRIGGER_LENGTH
// BEHAVIOUR
//  - Reset (async on ARESETN low, release synchronous to ACLK): state IDLE, fifo empty, counters 0.
//    Output reset values: S_AXIS_TREADY=0 while reset is asserted, then 1 once in IDLE;
//    M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TKEEP=16'hFFFF, M_AXIS_TDATA=0, OVERFLOW=0.
//  - Reset mid-frame discards the partial frame. No partial packet resumes after reset.
//  - FSM: IDLE -> COLLECT on the first accepted line.
//    COLLECT -> HEADER on an accepted line with TLAST (an IDLE line with TLAST goes straight to HEADER).
//    HEADER -> DATA on handshake. DATA -> FOOTER on the handshake of the last stored line.
//    FOOTER -> IDLE on handshake.
//  - Data-line handshake: a line is accepted on S_AXIS_TVALID & S_AXIS_TREADY. Lines 1..MAX are
//    written to the line fifo; later lines are accepted and dropped, and an overflow flag is set.
//  - Line count n: counter width $clog2(MAX)+1. Header length field is 2*n, in 64-bit words,
//    truncated to FRAME_LENGTH_WIDTH.
//  - Header line, TKEEP=16'hFFFF:
//    TDATA = {64'b0, HEADER_ID, CHANNEL_ID, frame_len, 32'b0}.
//  - Data lines: fifo contents, in order, unmodified, TKEEP=16'hFFFF.
//  - Footer line: TDATA = {64'b0, FOOTER_ID, footer_payload[55:0]}, TKEEP=16'h00FF, TLAST=1.
//  - Latency: the header is valid on the cycle after the TLAST line is accepted.
//    Back-to-back lines are sent with zero bubbles while M_AXIS_TREADY stays high.
//  - Output rule: M_AXIS_* are registered and held stable while TVALID & !TREADY.
//  - OVERFLOW pulses in the cycle the header is first presented when the flag is set;
//    the flag is then cleared.
//  - Next window: S_AXIS_TREADY returns to 1 the cycle after the footer handshake.
// CONFIGURATION
//  FRAME_BUILDER_TIMESTAMP_EN defined:
//    A 56-bit free-running cycle counter runs from reset.
//    It is latched on the first accepted line of the window, and footer_payload = the latched value.
//  FRAME_BUILDER_TIMESTAMP_EN undefined:
//    footer_payload = {56{1'b1}}. No counter is built.
// STRUCTURE
//  - Package frame_builder_pkg: HEADER_ID/FOOTER_ID constants, the state enum
//    {IDLE, COLLECT, HEADER, DATA, FOOTER}, and the header/footer bit-position localparams.
//  - Sub-module frame_line_fifo: synchronous fifo, MAX_TRIGGER_LENGTH x 128, first-word fall-through.
//    Ports: wr_en, rd_en, full, empty. Reset through ARESETN.
// TESTING
//  1 4-line window, CH=12'h003, M_AXIS_TREADY=1 -> header {64'b0,AA,003,008,32'b0};
//    then 4 data lines identical to the input; then footer with TKEEP=00FF, TLAST=1. Total 6 beats, no gaps.
//  2 1-line window (TVALID+TLAST in IDLE) -> frame_len=2; 3-beat packet; OVERFLOW stays 0.
//  3 20-line window, MAX=16 -> all 20 lines accepted, first 16 sent, frame_len=32 (12'h020);
//    OVERFLOW=1 for exactly one cycle.
//  4 Random M_AXIS_TREADY (50%) and random S_AXIS_TVALID gaps, 512 windows of 1..4 lines ->
//    every packet matches the reference model; TDATA is held stable while stalled.
//  5 ARESETN low during DATA of window A -> M_AXIS_TVALID=0 asynchronously;
//    the next window B is framed correctly with no A residue.
//  6 TIMESTAMP_EN build -> footer[55:0] equals the cycle count at the first line;
//    it is strictly increasing across frames. Non-EN build -> footer[55:0] = all ones.

Source files
------------

// File: rtl/frame_builder_pkg.sv
// Shared constants and types for the AXI4-Stream frame builder.
// Header line layout (low 64 bits): [63:56] HEADER_ID, [55:44] channel, [43:32] length.
// Footer line layout (low 64 bits): [63:56] FOOTER_ID, [55:0] payload.
package frame_builder_pkg;

  localparam logic [7:0] HEADER_ID = 8'hAA;
  localparam logic [7:0] FOOTER_ID = 8'h55;

  localparam int unsigned HDR_LEN_LSB   = 32;
  localparam int unsigned HDR_CH_LSB    = 44;
  localparam int unsigned HDR_ID_LSB    = 56;
  localparam int unsigned FTR_ID_LSB    = 56;
  localparam int unsigned FTR_PAYLOAD_W = 56;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HEADER,
    DATA,
    FOOTER
  } state_e;

endpackage

// File: rtl/frame_line_fifo.sv
// Line buffer for one trigger window: DEPTH x WIDTH synchronous fifo with
// first-word fall-through (rd_data_o shows the head entry while !empty).
module frame_line_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_wr     = wr_en & ~full;
  assign do_rd     = rd_en & ~empty;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; data only, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_frame_builder.sv
// Transmit-side framer: buffers one trigger window of 128-bit sample lines and
// emits header, data lines and a TLAST footer as one AXI4-Stream packet.
// Optional build macro FRAME_BUILDER_TIMESTAMP_EN: footer payload carries the
// free-running cycle count latched on the window's first line (else all ones).
module axis_frame_builder #(
  parameter int unsigned TDATA_WIDTH        = 128,
  parameter int unsigned CHANNEL_ID_WIDTH   = 12,
  parameter int unsigned FRAME_LENGTH_WIDTH = 12,
  parameter int unsigned MAX_TRIGGER_LENGTH = 16,
  parameter logic [7:0]  HEADER_ID          = frame_builder_pkg::HEADER_ID,
  parameter logic [7:0]  FOOTER_ID          = frame_builder_pkg::FOOTER_ID
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [CHANNEL_ID_WIDTH-1:0]   CHANNEL_ID,
  input  logic [TDATA_WIDTH-1:0]        S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  input  logic                          S_AXIS_TLAST,
  output logic                          S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0]        M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0]      M_AXIS_TKEEP,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  output logic                          OVERFLOW
);

  import frame_builder_pkg::*;

  localparam int unsigned KW = TDATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(MAX_TRIGGER_LENGTH) + 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_TRIGGER_LENGTH);
  localparam logic [KW-1:0] FTR_KEEP = {{(KW/2){1'b0}}, {(KW/2){1'b1}}};

  state_e                        state_q;
  logic                          s_ready_q;
  logic                          m_valid_q;
  logic                          m_last_q;
  logic [KW-1:0]                 m_keep_q;
  logic [TDATA_WIDTH-1:0]        m_data_q;
  logic                          overflow_q;
  logic                          ovf_flag_q, ovf_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [CHANNEL_ID_WIDTH-1:0]   ch_q, ch_d;
  logic [CW:0]                   len_wide;
  logic [FRAME_LENGTH_WIDTH-1:0] len_d;
  logic [TDATA_WIDTH-1:0]        hdr_d;
  logic [TDATA_WIDTH-1:0]        ftr_d;
  logic [FTR_PAYLOAD_W-1:0]      payload;

  logic                   s_accept;
  logic                   first_line;
  logic                   m_hs;
  logic                   fifo_wr;
  logic                   fifo_rd;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [TDATA_WIDTH-1:0] fifo_rdata;

  assign s_accept   = S_AXIS_TVALID & s_ready_q;
  assign first_line = s_accept & (state_q == IDLE);
  assign m_hs       = m_valid_q & M_AXIS_TREADY;

  // Lines beyond MAX_TRIGGER_LENGTH are accepted but never stored.
  assign fifo_wr = s_accept & (first_line | (cnt_q != MAX_CNT)) & ~fifo_full;
  assign fifo_rd = m_hs & ((state_q == HEADER) | ((state_q == DATA) & ~fifo_empty));

  frame_line_fifo #(
    .DEPTH (MAX_TRIGGER_LENGTH),
    .WIDTH (TDATA_WIDTH)
  ) u_fifo (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .wr_en     (fifo_wr),
    .wr_data_i (S_AXIS_TDATA),
    .rd_en     (fifo_rd),
    .rd_data_o (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FRAME_BUILDER_TIMESTAMP_EN
  logic [FTR_PAYLOAD_W-1:0] tsc_q;
  logic [FTR_PAYLOAD_W-1:0] ts_q;

  // Free-running cycle counter, sampled on the first line of each window.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tsc_q <= '0;
      ts_q  <= '0;
    end else begin
      tsc_q <= tsc_q + FTR_PAYLOAD_W'(1);
      if (first_line) ts_q <= tsc_q;
    end
  end

  assign payload = ts_q;
`else
  assign payload = '1;
`endif

  // Window bookkeeping after the current input beat, plus header/footer words.
  // The header uses these next-state values so a TLAST line is counted in it.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_flag_q;
    ch_d  = ch_q;
    if (first_line) begin
      cnt_d = CW'(1);
      ovf_d = 1'b0;
      ch_d  = CHANNEL_ID;
    end else if (s_accept) begin
      if (cnt_q == MAX_CNT) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CW'(1);
    end
    len_wide = {cnt_d, 1'b0};
    len_d    = FRAME_LENGTH_WIDTH'(len_wide);

    hdr_d = '0;
    hdr_d[HDR_ID_LSB +: 8]                   = HEADER_ID;
    hdr_d[HDR_CH_LSB +: CHANNEL_ID_WIDTH]    = ch_d;
    hdr_d[HDR_LEN_LSB +: FRAME_LENGTH_WIDTH] = len_d;

    ftr_d = '0;
    ftr_d[FTR_ID_LSB +: 8]       = FOOTER_ID;
    ftr_d[FTR_PAYLOAD_W-1:0]     = payload;
  end

  // Framing FSM with registered stream outputs; outputs only move on a
  // handshake or when the header is first loaded, so they hold while stalled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_keep_q   <= '1;
      m_data_q   <= '0;
      overflow_q <= 1'b0;
      ovf_flag_q <= 1'b0;
      cnt_q      <= '0;
      ch_q       <= '0;
    end else begin
      overflow_q <= 1'b0;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_d;
      ch_q       <= ch_d;
      unique case (state_q)
        IDLE, COLLECT: begin
          s_ready_q <= 1'b1;
          if (s_accept) begin
            if (S_AXIS_TLAST) begin
              state_q    <= HEADER;
              s_ready_q  <= 1'b0;
              m_valid_q  <= 1'b1;
              m_last_q   <= 1'b0;
              m_keep_q   <= '1;
              m_data_q   <= hdr_d;
              overflow_q <= ovf_d;
              ovf_flag_q <= 1'b0;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        HEADER: begin
          if (m_hs) begin
            state_q  <= DATA;
            m_data_q <= fifo_rdata;
          end
        end
        DATA: begin
          if (m_hs) begin
            if (!fifo_empty) begin
              m_data_q <= fifo_rdata;
            end else begin
              state_q  <= FOOTER;
              m_data_q <= ftr_d;
              m_keep_q <= FTR_KEEP;
              m_last_q <= 1'b1;
            end
          end
        end
        FOOTER: begin
          if (m_hs) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_keep_q  <= '1;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TKEEP  = m_keep_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign OVERFLOW      = overflow_q;

endmodule

// File: tb/tb_axis_frame_builder.sv
// Self-checking bench for axis_frame_builder: windows of random sample lines
// are framed by a packet-level reference model and compared beat by beat.
module tb_axis_frame_builder;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [11:0]  CHANNEL_ID = '0;
  logic [127:0] S_AXIS_TDATA = '0;
  logic         S_AXIS_TVALID = 1'b0;
  logic         S_AXIS_TLAST = 1'b0;
  logic         S_AXIS_TREADY;
  logic [127:0] M_AXIS_TDATA;
  logic [15:0]  M_AXIS_TKEEP;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TREADY = 1'b1;
  logic         OVERFLOW;

  always #5 ACLK = ~ACLK;

  axis_frame_builder dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .CHANNEL_ID    (CHANNEL_ID),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .OVERFLOW      (OVERFLOW)
  );

  int checks = 0;
  int errors = 0;

  // Beats are {TLAST, TKEEP, TDATA}.
  logic [144:0]    exp_q[$];
  logic [144:0]    obs_q[$];
  longint unsigned obs_cyc[$];

  longint unsigned cyc = 0;
  longint unsigned first_acc_cyc;
  longint unsigned last_acc_cyc;
  int              ready_mode = 0;
  int              ovf_pulses = 0;
  int              ovf_misalign = 0;
  int              stall_viol = 0;
  bit              stall_prev = 0;
  logic [145:0]    stall_beat;

  // Reference cycle count: posedges seen since reset release.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Downstream ready: always high, or a 50% coin toss per cycle.
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      M_AXIS_TREADY = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Output monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
        obs_q.push_back({M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA});
        obs_cyc.push_back(cyc);
      end
      if (ARESETN && stall_prev &&
          ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} !== stall_beat))
        stall_viol++;
      stall_prev = ARESETN && M_AXIS_TVALID && !M_AXIS_TREADY;
      stall_beat = {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA};
      if (ARESETN && OVERFLOW) begin
        ovf_pulses++;
        if (!(M_AXIS_TVALID && M_AXIS_TDATA[63:56] == 8'hAA)) ovf_misalign++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  // Drive one window of m random lines and append the expected packet.
  task automatic send_window(input int m, input bit gaps, input logic [11:0] ch);
    logic [127:0] lines[$];
    logic [127:0] d;
    logic [127:0] hdr;
    logic [127:0] ftr;
    logic [55:0]  pay;
    bit acc;
    int guard;
    int n;
    for (int i = 0; i < m; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          S_AXIS_TVALID = 1'b0;
          @(posedge ACLK);
          #1;
        end
      end
      S_AXIS_TDATA  = d;
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TLAST  = (i == m - 1);
      CHANNEL_ID    = ch;
      acc = 0;
      guard = 0;
      while (!acc && guard < 2000) begin
        @(negedge ACLK);
        acc = S_AXIS_TREADY;
        if (acc && i == 0)     first_acc_cyc = cyc;
        if (acc && i == m - 1) last_acc_cyc  = cyc;
        @(posedge ACLK);
        #1;
        guard++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL input_accept line %0d: TREADY got 0 want 1 within 2000 cycles", i);
      end
      lines.push_back(d);
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;

    n = (m > 16) ? 16 : m;
    hdr = {64'b0, 8'hAA, ch, 12'(2 * n), 32'b0};
    exp_q.push_back({1'b0, 16'hFFFF, hdr});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 16'hFFFF, lines[i]});
`ifdef FRAME_BUILDER_TIMESTAMP_EN
    pay = first_acc_cyc[55:0];
`else
    pay = {56{1'b1}};
`endif
    ftr = {64'b0, 8'h55, pay};
    exp_q.push_back({1'b1, 16'h00FF, ftr});
  endtask

  // Wait (bounded) until the monitor has seen as many beats as expected.
  task automatic drain();
    int g = 0;
    while (obs_q.size() < exp_q.size() && g < 5000) begin
      @(posedge ACLK);
      #1;
      g++;
    end
    repeat (4) @(posedge ACLK);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    ovf_pulses = 0;
    ovf_misalign = 0;
    stall_viol = 0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b want 0", S_AXIS_TREADY); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", M_AXIS_TLAST); end
    checks++; if (M_AXIS_TKEEP !== 16'hFFFF) begin errors++; $display("FAIL reset_tkeep got %h want ffff", M_AXIS_TKEEP); end
    checks++; if (M_AXIS_TDATA !== 128'b0) begin errors++; $display("FAIL reset_tdata got %h want 0", M_AXIS_TDATA); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", OVERFLOW); end
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL idle_s_tready got %b want 1", S_AXIS_TREADY); end
    clear_queues();
  endtask

  task automatic test_four_line();
    logic [144:0] hdr_beat;
    ready_mode = 0;
    send_window(4, 0, 12'h003);
    drain();
    hdr_beat = {1'b0, 16'hFFFF, 64'b0, 8'hAA, 12'h003, 12'h008, 32'b0};
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL four_line_beats got %0d want 6", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== hdr_beat) begin errors++; $display("FAIL four_line_header got %h want %h", obs_q[0], hdr_beat); end
      checks++; if (obs_cyc[0] != last_acc_cyc + 1) begin errors++; $display("FAIL four_line_latency got cycle %0d want %0d", obs_cyc[0], last_acc_cyc + 1); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL four_line_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      if (i > 0) begin
        checks++;
        if (obs_cyc[i] != obs_cyc[0] + i) begin errors++; $display("FAIL four_line_gap%0d got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
      end
    end
    clear_queues();
  endtask

  task automatic test_single_line();
    ready_mode = 0;
    send_window(1, 0, 12'(($urandom_range(0, 4095))));
    drain();
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL single_beats got %0d want 3", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf_pulses != 0) begin errors++; $display("FAIL single_overflow got %0d pulses want 0", ovf_pulses); end
    clear_queues();
  endtask

  task automatic test_overflow();
    ready_mode = 0;
    // Exactly MAX lines: full frame, no overflow.
    send_window(16, 0, 12'h7A5);
    drain();
    checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL max_beats got %0d want 18", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL max_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf_pulses != 0) begin errors++; $display("FAIL max_overflow got %0d pulses want 0", ovf_pulses); end
    clear_queues();
    // 20 lines: first 16 sent, length 12'h020, one overflow pulse on the header.
    send_window(20, 1, 12'h123);
    drain();
    checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL ovf_beats got %0d want 18", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0][43:32] !== 12'h020) begin errors++; $display("FAIL ovf_len got %h want 020", obs_q[0][43:32]); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ovf_pulses != 1) begin errors++; $display("FAIL ovf_pulse got %0d cycles want 1", ovf_pulses); end
    checks++; if (ovf_misalign != 0) begin errors++; $display("FAIL ovf_align got %0d off-header pulses want 0", ovf_misalign); end
    clear_queues();
  endtask

  task automatic test_random();
    int bad = 0;
    ready_mode = 1;
    for (int w = 0; w < 512; w++)
      send_window($urandom_range(1, 4), 1, 12'($urandom_range(0, 4095)));
    drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        bad++;
        if (bad <= 8) $display("FAIL random_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL random_stall_hold got %0d changes want 0", stall_viol); end
    checks++; if (ovf_pulses != 0) begin errors++; $display("FAIL random_overflow got %0d pulses want 0", ovf_pulses); end
    ready_mode = 0;
    repeat (2) @(posedge ACLK);
    #1;
    clear_queues();
  endtask

  task automatic test_reset_mid_frame();
    ready_mode = 0;
    send_window(4, 0, 12'h0A0);
    // Header is presented now; one more edge moves into the data lines.
    @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL midreset_tvalid got %b want 0", M_AXIS_TVALID); end
    checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL midreset_s_tready got %b want 0", S_AXIS_TREADY); end
    @(posedge ACLK);
    #1;
    clear_queues();
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    checks++; if (S_AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL midreset_ready_back got %b want 1", S_AXIS_TREADY); end
    send_window(3, 1, 12'h0B0);
    drain();
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL midreset_beats got %0d want 5", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    clear_queues();
  endtask

  task automatic test_timestamp();
    logic [55:0] pays[$];
    ready_mode = 0;
    for (int w = 0; w < 3; w++) begin
      repeat ($urandom_range(1, 5)) @(posedge ACLK);
      #1;
      send_window(2, 1, 12'(w));
    end
    drain();
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ts_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      if (obs_q[i][144]) pays.push_back(obs_q[i][55:0]);
    end
    checks++; if (pays.size() != 3) begin errors++; $display("FAIL ts_footers got %0d want 3", pays.size()); end
    for (int k = 0; k < pays.size(); k++) begin
`ifdef FRAME_BUILDER_TIMESTAMP_EN
      if (k > 0) begin
        checks++;
        if (!(pays[k] > pays[k-1])) begin errors++; $display("FAIL ts_increase%0d got %h want > %h", k, pays[k], pays[k-1]); end
      end
`else
      checks++;
      if (pays[k] !== {56{1'b1}}) begin errors++; $display("FAIL ts_ones%0d got %h want all ones", k, pays[k]); end
`endif
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_four_line();
    test_single_line();
    test_overflow();
    test_random();
    test_reset_mid_frame();
    test_timestamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
